vga_scan_engine: RTL and testbench
==================================

Name: vga_scan_engine

Overview:
Parametrised VGA scan engine, successor to the fixed 640x480 controller used with the RAM framebuffer path.
- Generates configurable h/v timing and framebuffer read addresses, with optional 2x pixel scaling.
- Compensates a configurable RAM read latency, so sync, valid and colour leave aligned.
- Expands N-bit colour channels to full output width by bit replication instead of zero padding.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
DW, 4, colour bits per channel on rd_data
OUT_W, 8, colour bits per channel on outputs (OUT_W >= DW)
RD_LAT, 1, framebuffer read latency in pix_en ticks (0..4)

Ports:
clk  in  1  system clock
clear  in  1  synchronous active-low reset
pix_en  in  1  pixel-tick strobe; all state advances only when high
mode_2x  in  1  1 = 2x scaled (addresses halved)
rd_addr_x  out  10  framebuffer column address
rd_addr_y  out  9  framebuffer row address
rd_data  in  3*DW  {r,g,b} for the address issued RD_LAT ticks earlier
vga_r  out  OUT_W  red
vga_g  out  OUT_W  green
vga_b  out  OUT_W  blue
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
valid  out  1  visible-pixel flag, aligned with colour
frame_start  out  1  one-tick pulse with first visible pixel of a frame
line_start  out  1  one-tick pulse with first visible pixel of each line

Behaviour:
- Reset, sampled on the clk edge while clear=0, wins over pix_en:
  - h_cnt=0, v_cnt=0, delay line cleared, mode_q=0.
  - Colours=0, valid=0, frame_start=0, line_start=0.
  - hsync=vsync=~SYNC_POL (inactive).
- Counters: on pix_en, h_cnt increments and wraps at H_TOT-1 (H_TOT = sum of H params) to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps at V_TOT-1 to 0.
  - pix_en=0: every register holds.
- Raw timing (stage 0):
  - act = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted likewise on v_cnt.
- Address, combinational from counters and mode_q:
  - act=1, mode_q=0: (h_cnt, v_cnt).
  - act=1, mode_q=1: (h_cnt>>1, v_cnt>>1).
  - act=0: both addresses 0.
- mode_q: samples mode_2x only on the pix_en tick where h_cnt=H_TOT-1 and v_cnt=V_TOT-1. A mid-frame change takes effect at the next frame.
- Alignment:
  - act, hs, vs, frame-first and line-first flags pass through an RD_LAT-deep shift register clocked by pix_en.
  - Then one output register.
  - Total latency from counter state to pins = RD_LAT+1 pix_en ticks.
  - rd_data is sampled into the output register on the same tick as the delayed flags.
- Colour:
  - Each channel is replicated MSB-first to OUT_W bits and truncated (DW=4, OUT_W=8: 0xA -> 0xAA; DW=5, OUT_W=8: c -> {c, c[4:2]}).
  - Forced to 0 when delayed act=0.
- Sync output = SYNC_POL when asserted, ~SYNC_POL otherwise.
- Pulse alignment:
  - frame_start: h_cnt=0 && v_cnt=0, delayed.
  - line_start: h_cnt=0 && v_cnt<V_ACTIVE, delayed.
  - Each lasts exactly one pix_en-qualified clk cycle (cleared on the next clk cycle even if pix_en=0).
- Reset mid-frame restarts at (0,0) on the next tick with the pipeline empty. The first RD_LAT+1 ticks output inactive syncs and valid=0.

Test Plan:
- Default params, pix_en=1, clear released → hsync low for exactly 96 clk, period 800; vsync low 2 lines (1600 clk), period 420000 clk; valid high 640 per line, 480 lines.
- RD_LAT=1; RAM model returns {addr_x[3:0], addr_y[3:0], 4'h5} → at pixel (3,2) outputs r=0x33, g=0x22, b=0x55; valid rises exactly 2 clk after h_cnt=0 on line 0.
- rd_data=12'hFFF held during blanking → colours stay 0 whenever valid=0.
- mode_2x raised at line 100 → addresses unscaled for rest of frame; next frame pixel (639,479) reads (319,239).
- pix_en toggling 1-of-2 cycles → sync widths double in clk (192), outputs stable across gaps, pulses last one clk.
- clear=0 for one cycle at h_cnt=300, v_cnt=50 → next cycle counters 0, outputs reset values; frame_start appears RD_LAT+1 ticks later.

Source files
------------

// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan engine: h/v timing, framebuffer addressing with optional 2x scaling,
// read-latency compensation and bit-replicated colour expansion.
module vga_scan_engine #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned DW       = 4,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              pix_en,
  input  logic              mode_2x,
  output logic [9:0]        rd_addr_x,
  output logic [8:0]        rd_addr_y,
  input  logic [3*DW-1:0]   rd_data,
  output logic [OUT_W-1:0]  vga_r,
  output logic [OUT_W-1:0]  vga_g,
  output logic [OUT_W-1:0]  vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic              frame_start,
  output logic              line_start
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned FW    = 5;
  localparam int unsigned REP   = (OUT_W + DW - 1) / DW;
  localparam logic        SP    = 1'(SYNC_POL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          mode_q;
  logic          h_last;
  logic          v_last;

  assign h_last = (32'(h_cnt) == H_TOT - 1);
  assign v_last = (32'(v_cnt) == V_TOT - 1);

  // Raster counters; scaling mode is only latched at the frame boundary.
  always_ff @(posedge clk) begin
    if (!clear) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      mode_q <= 1'b0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt  <= '0;
          mode_q <= mode_2x;
        end else begin
          v_cnt <= v_cnt + VW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  logic          act;
  logic          hs;
  logic          vs;
  logic          fs;
  logic          ls;
  logic [FW-1:0] flags0;

  always_comb begin
    act    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs     = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs     = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    fs     = (h_cnt == '0) && (v_cnt == '0);
    ls     = (h_cnt == '0) && (32'(v_cnt) < V_ACTIVE);
    flags0 = {ls, fs, vs, hs, act};
  end

  // Framebuffer address; blanking always reads location zero.
  always_comb begin
    rd_addr_x = '0;
    rd_addr_y = '0;
    if (act) begin
      if (mode_q) begin
        rd_addr_x = 10'(h_cnt >> 1);
        rd_addr_y = 9'(v_cnt >> 1);
      end else begin
        rd_addr_x = 10'(h_cnt);
        rd_addr_y = 9'(v_cnt);
      end
    end
  end

  logic [FW-1:0] flags_d;

  generate
    if (RD_LAT == 0) begin : g_nodly
      assign flags_d = flags0;
    end else begin : g_dly
      localparam int unsigned SRW = FW * RD_LAT;
      logic [SRW-1:0] sr;

      // Timing flags wait here while the RAM read is in flight.
      always_ff @(posedge clk) begin
        if (!clear) begin
          sr <= '0;
        end else if (pix_en) begin
          sr <= SRW'({sr, flags0});
        end
      end

      assign flags_d = sr[SRW-1 -: FW];
    end
  endgenerate

  logic act_d;
  logic hs_d;
  logic vs_d;
  logic fs_d;
  logic ls_d;

  assign {ls_d, fs_d, vs_d, hs_d, act_d} = flags_d;

  function automatic logic [OUT_W-1:0] expand(input logic [DW-1:0] c);
    return OUT_W'({REP{c}} >> (REP * DW - OUT_W));
  endfunction

  // Output register; start pulses drop on the very next clk even without pix_en.
  always_ff @(posedge clk) begin
    if (!clear) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= ~SP;
      vsync       <= ~SP;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_en) begin
        vga_r       <= act_d ? expand(rd_data[3*DW-1 -: DW]) : '0;
        vga_g       <= act_d ? expand(rd_data[2*DW-1 -: DW]) : '0;
        vga_b       <= act_d ? expand(rd_data[DW-1:0])      : '0;
        hsync       <= hs_d ? SP : ~SP;
        vsync       <= vs_d ? SP : ~SP;
        valid       <= act_d;
        frame_start <= fs_d;
        line_start  <= ls_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a shrunken raster: raster-position reference model plus a latency-matched RAM.
module tb_vga_scan_engine;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int DW       = 5;
  localparam int OUT_W    = 8;
  localparam int LAT      = 2;
  localparam logic SP     = 1'b0;
  localparam logic [28:0] RESET_VEC = {24'h0, ~SP, ~SP, 3'b000};

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
    logic [9:0] x;
    logic [8:0] y;
  } rec_t;

  logic              clk;
  logic              clear;
  logic              pix_en;
  logic              mode_2x;
  logic [9:0]        rd_addr_x;
  logic [8:0]        rd_addr_y;
  logic [3*DW-1:0]   rd_data;
  logic [OUT_W-1:0]  vga_r;
  logic [OUT_W-1:0]  vga_g;
  logic [OUT_W-1:0]  vga_b;
  logic              hsync;
  logic              vsync;
  logic              valid;
  logic              frame_start;
  logic              line_start;

  vga_scan_engine #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .DW(DW), .OUT_W(OUT_W), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .clear(clear), .pix_en(pix_en), .mode_2x(mode_2x),
    .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .frame_start(frame_start), .line_start(line_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RAM contents; location (0,0) is all ones so blanking reads non-zero data.
  function automatic logic [14:0] ram_data(input logic [9:0] x, input logic [8:0] y);
    if (x == 10'd0 && y == 9'd0) return 15'h7FFF;
    return {x[4:0], y[4:0], 5'(x[4:0] + y[4:0] + 5'd3)};
  endfunction

  logic [14:0] ram_pipe [LAT];
  logic [18:0] addr_s;

  always @(negedge clk) addr_s <= {rd_addr_x, rd_addr_y};

  always @(posedge clk) begin
    if (pix_en && clear) begin
      ram_pipe[0] <= ram_data(addr_s[18:9], addr_s[8:0]);
      for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
  end

  assign rd_data = ram_pipe[LAT-1];

  // Reference model: pixel ticks since reset, scaling mode of the current frame, recent raster history.
  int   m = 0;
  logic mode_cur = 1'b0;
  logic pulse_live = 1'b0;
  rec_t hist[$];

  function automatic rec_t pos_info(input int j, input logic md);
    rec_t r;
    int h, v;
    h = j % H_TOT;
    v = (j / H_TOT) % V_TOT;
    r.act = (h < H_ACTIVE) && (v < V_ACTIVE);
    r.hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    r.vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    r.fs  = (h == 0) && (v == 0);
    r.ls  = (h == 0) && (v < V_ACTIVE);
    r.x   = r.act ? 10'(md ? h / 2 : h) : 10'd0;
    r.y   = r.act ? 9'(md ? v / 2 : v) : 9'd0;
    return r;
  endfunction

  function automatic logic [7:0] expand(input logic [4:0] c);
    logic [9:0] t;
    t = {c, c};
    return t[9:2];
  endfunction

  function automatic logic [28:0] exp_out();
    rec_t r;
    logic [14:0] d;
    if (m <= LAT) return RESET_VEC;
    r = hist[0];
    d = ram_data(r.x, r.y);
    return {r.act ? expand(d[14:10]) : 8'h0, r.act ? expand(d[9:5]) : 8'h0,
            r.act ? expand(d[4:0]) : 8'h0, r.hs ? SP : ~SP, r.vs ? SP : ~SP,
            r.act, r.fs & pulse_live, r.ls & pulse_live};
  endfunction

  function automatic logic [18:0] exp_addr();
    rec_t r;
    r = pos_info(m, mode_cur);
    return {r.x, r.y};
  endfunction

  logic [28:0] obs;
  logic [18:0] obs_addr;
  assign obs      = {vga_r, vga_g, vga_b, hsync, vsync, valid, frame_start, line_start};
  assign obs_addr = {rd_addr_x, rd_addr_y};

  task automatic step(input logic en, input logic clr, input logic md);
    pix_en  = en;
    clear   = clr;
    mode_2x = md;
    @(posedge clk);
    if (!clr) begin
      m = 0;
      mode_cur = 1'b0;
      pulse_live = 1'b0;
      hist.delete();
    end else if (en) begin
      hist.push_back(pos_info(m, mode_cur));
      if (hist.size() > LAT + 1) void'(hist.pop_front());
      if (m % FRAME == FRAME - 1) mode_cur = md;
      m++;
      pulse_live = 1'b1;
    end else begin
      pulse_live = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b0, 1'($urandom % 2));
      checks++;
      if (obs !== RESET_VEC) begin
        errors++; $display("FAIL reset_out got %h want %h", obs, RESET_VEC);
      end
      checks++;
      if (obs_addr !== 19'd0) begin
        errors++; $display("FAIL reset_addr got %h want 0", obs_addr);
      end
    end
  endtask

  task automatic test_full_frame();
    int hrun = 0, vrun = 0, vcount = 0, first_v = -1;
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2 * FRAME + LAT + 4; n++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL frame_out m=%0d got %h want %h", m, obs, exp_out());
      end
      checks++;
      if (obs_addr !== exp_addr()) begin
        errors++; $display("FAIL frame_addr m=%0d got %h want %h", m, obs_addr, exp_addr());
      end
      if (valid === 1'b1 && first_v < 0) first_v = m;
      if (m >= LAT + 1 && m <= LAT + FRAME && valid === 1'b1) vcount++;
      if (hsync === 1'b0) hrun++;
      else if (hrun > 0) begin
        checks++;
        if (hrun != H_SYNC) begin
          errors++; $display("FAIL hsync_width got %0d want %0d", hrun, H_SYNC);
        end
        hrun = 0;
      end
      if (vsync === 1'b0) vrun++;
      else if (vrun > 0) begin
        checks++;
        if (vrun != V_SYNC * H_TOT) begin
          errors++; $display("FAIL vsync_width got %0d want %0d", vrun, V_SYNC * H_TOT);
        end
        vrun = 0;
      end
      if (m - 1 - LAT == 2 * H_TOT + 3) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h181042) begin
          errors++; $display("FAIL pixel_3_2 got %h want 181042", {vga_r, vga_g, vga_b});
        end
      end
    end
    checks++;
    if (first_v != LAT + 1) begin
      errors++; $display("FAIL valid_latency got %0d want %0d", first_v, LAT + 1);
    end
    checks++;
    if (vcount != H_ACTIVE * V_ACTIVE) begin
      errors++; $display("FAIL valid_count got %0d want %0d", vcount, H_ACTIVE * V_ACTIVE);
    end
  endtask

  task automatic test_mode_2x();
    step(1'b1, 1'b0, 1'b0);
    while (m < FRAME + 7 * H_TOT + 15 + LAT + 2) begin
      step(1'b1, 1'b1, 1'(m >= 3 * H_TOT));
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL mode_out m=%0d got %h want %h", m, obs, exp_out());
      end
      checks++;
      if (obs_addr !== exp_addr()) begin
        errors++; $display("FAIL mode_addr m=%0d got %h want %h", m, obs_addr, exp_addr());
      end
      if (m == 5 * H_TOT + 10) begin
        checks++;
        if (obs_addr !== {10'd10, 9'd5}) begin
          errors++; $display("FAIL mode_midframe got %h want %h", obs_addr, {10'd10, 9'd5});
        end
      end
      if (m == FRAME + 7 * H_TOT + 15) begin
        checks++;
        if (obs_addr !== {10'd7, 9'd3}) begin
          errors++; $display("FAIL mode_scaled got %h want %h", obs_addr, {10'd7, 9'd3});
        end
      end
    end
  endtask

  task automatic test_pix_en_gaps();
    int hrun = 0, fsrun = 0, lsrun = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4 * FRAME + 8; n++) begin
      step(1'(n % 2 == 0), 1'b1, 1'b0);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL gaps_out n=%0d got %h want %h", n, obs, exp_out());
      end
      if (hsync === 1'b0) hrun++;
      else if (hrun > 0) begin
        checks++;
        if (hrun != 2 * H_SYNC) begin
          errors++; $display("FAIL gaps_hsync got %0d want %0d", hrun, 2 * H_SYNC);
        end
        hrun = 0;
      end
      if (frame_start === 1'b1) fsrun++;
      else if (fsrun > 0) begin
        checks++;
        if (fsrun != 1) begin
          errors++; $display("FAIL gaps_frame_pulse got %0d want 1", fsrun);
        end
        fsrun = 0;
      end
      if (line_start === 1'b1) lsrun++;
      else if (lsrun > 0) begin
        checks++;
        if (lsrun != 1) begin
          errors++; $display("FAIL gaps_line_pulse got %0d want 1", lsrun);
        end
        lsrun = 0;
      end
    end
  endtask

  task automatic test_random();
    logic md = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 50 == 0) md = ~md;
      step(1'($urandom % 4 != 0), 1'($urandom % 400 != 0), md);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL rand_out n=%0d got %h want %h", n, obs, exp_out());
      end
      checks++;
      if (obs_addr !== exp_addr()) begin
        errors++; $display("FAIL rand_addr n=%0d got %h want %h", n, obs_addr, exp_addr());
      end
    end
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    while (m < 3 * H_TOT + 10) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL midreset_out got %h want %h", obs, RESET_VEC);
    end
    checks++;
    if (obs_addr !== 19'd0) begin
      errors++; $display("FAIL midreset_addr got %h want 0", obs_addr);
    end
    while (cnt < 20) begin
      step(1'b1, 1'b1, 1'b0);
      cnt++;
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL midreset_pipe cnt=%0d got %h want %h", cnt, obs, exp_out());
      end
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (cnt != LAT + 1) begin
      errors++; $display("FAIL midreset_frame_start got %0d want %0d", cnt, LAT + 1);
    end
  endtask

  initial begin
    clear   = 1'b0;
    pix_en  = 1'b0;
    mode_2x = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_mode_2x();
    test_pix_en_gaps();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
